// File: rtl/router_frame_arbiter.sv
// ---------------------------------------------------------------------------
// router_frame_arbiter
//   Round-robin scheduler that shares the single data_router input stream
//   between NUM_SRC requesters. A granted requester's descriptor becomes a
//   header word {pkt_cnt, cfg_len}. After the header, the block forwards
//   cfg_len config words and then pkt_cnt data words from that source, and
//   then arbitrates again.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   s_req_valid/ready          per-source descriptor handshake (ready = 1-cycle one-hot pulse)
//   s_req_cfg_len              per-source config word count (10 bits each)
//   s_req_pkt_cnt              per-source data word count (CNT_W bits each)
//   s_axis_src_data/valid      per-source word stream into the block
//   s_axis_src_ready           per-source stream ready, only the granted bit can be set
//   m_axis_router_input*       stream towards data_router
//   grant_id                   index of the current owner
//   busy                       high whenever the FSM is not IDLE
//   req_err                    1-cycle pulse when a descriptor has cfg_len > MAX_CFG_LEN
// ---------------------------------------------------------------------------
module router_frame_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int MAX_CFG_LEN = 8,
  parameter int CNT_W       = 16,
  localparam int GNT_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            s_req_valid,
  output logic [NUM_SRC-1:0]            s_req_ready,
  input  logic [NUM_SRC*10-1:0]         s_req_cfg_len,
  input  logic [NUM_SRC*CNT_W-1:0]      s_req_pkt_cnt,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_src_data,
  input  logic [NUM_SRC-1:0]            s_axis_src_valid,
  output logic [NUM_SRC-1:0]            s_axis_src_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_router_input,
  output logic                          m_axis_router_input_valid,
  input  logic                          m_axis_router_input_ready,
  output logic [GNT_W-1:0]              grant_id,
  output logic                          busy,
  output logic [NUM_SRC-1:0]            req_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_HDR  = 3'd2,
    S_CFG  = 3'd3,
    S_DATA = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [GNT_W-1:0]        r_rr;
  logic [GNT_W-1:0]        r_grant;
  logic [9:0]              r_cfg_rem;
  logic [CNT_W-1:0]        r_pkt_rem;

  logic [GNT_W-1:0]        w_sel;
  logic [GNT_W-1:0]        w_rr_nxt;
  logic                    w_found;
  logic                    w_take;
  int                      w_idx;
  logic [9:0]              w_sel_cfg;
  logic [CNT_W-1:0]        w_sel_pkt;
  logic                    w_cfg_bad;
  logic [DATA_WIDTH-1:0]   w_hdr;
  logic [DATA_WIDTH-1:0]   w_src_data;
  logic                    w_src_valid;
  logic                    w_hs;

  // Round-robin search: first requesting source at or after the rr pointer.
  always_comb begin
    w_found = 1'b0;
    w_take  = 1'b0;
    w_idx   = 0;
    w_sel   = r_rr;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_idx   = (int'(r_rr) + i) % NUM_SRC;
      w_take  = !w_found && s_req_valid[w_idx];
      w_sel   = w_take ? GNT_W'(w_idx) : w_sel;
      w_found = w_found | w_take;
    end
  end

  // Descriptor fields of the selected source, next rr pointer, and the granted stream.
  always_comb begin
    w_sel_cfg   = s_req_cfg_len[int'(w_sel)*10 +: 10];
    w_sel_pkt   = s_req_pkt_cnt[int'(w_sel)*CNT_W +: CNT_W];
    w_cfg_bad   = (w_sel_cfg > 10'(MAX_CFG_LEN));
    w_rr_nxt    = (w_sel == GNT_W'(NUM_SRC - 1)) ? {GNT_W{1'b0}} : (w_sel + GNT_W'(1));
    w_src_data  = s_axis_src_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
    w_src_valid = s_axis_src_valid[r_grant];
  end

  // Header word: counters still hold the latched descriptor while in HDR.
  always_comb begin
    w_hdr              = '0;
    w_hdr[9:0]         = r_cfg_rem;
    w_hdr[10 +: CNT_W] = r_pkt_rem;
  end

  // Next-state and output decode; CFG/DATA are a combinational pass-through of the owner.
  always_comb begin
    w_state_nxt               = r_state;
    s_req_ready               = '0;
    req_err                   = '0;
    s_axis_src_ready          = '0;
    m_axis_router_input       = '0;
    m_axis_router_input_valid = 1'b0;
    w_hs                      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = (|s_req_valid) ? S_ARB : S_IDLE;
      end
      S_ARB: begin
        if (!w_found) begin
          w_state_nxt = S_IDLE;
        end else begin
          // The descriptor is consumed either way; an oversized one only raises req_err.
          s_req_ready[w_sel] = 1'b1;
          if (w_cfg_bad) begin
            req_err[w_sel] = 1'b1;
            w_state_nxt    = S_IDLE;
          end else begin
            w_state_nxt    = S_HDR;
          end
        end
      end
      S_HDR: begin
        m_axis_router_input_valid = 1'b1;
        m_axis_router_input       = w_hdr;
        if (m_axis_router_input_ready) begin
          if (r_cfg_rem != 10'd0) begin
            w_state_nxt = S_CFG;
          end else if (r_pkt_rem != CNT_W'(0)) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_HDR;
        end
      end
      S_CFG, S_DATA: begin
        m_axis_router_input       = w_src_data;
        m_axis_router_input_valid = w_src_valid;
        s_axis_src_ready[r_grant] = m_axis_router_input_ready;
        w_hs                      = w_src_valid & m_axis_router_input_ready;
        if (!w_hs) begin
          w_state_nxt = r_state;
        end else if (r_state == S_CFG) begin
          if (r_cfg_rem == 10'd1) begin
            w_state_nxt = (r_pkt_rem != CNT_W'(0)) ? S_DATA : S_IDLE;
          end else begin
            w_state_nxt = S_CFG;
          end
        end else begin
          w_state_nxt = (r_pkt_rem == CNT_W'(1)) ? S_IDLE : S_DATA;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, rr pointer, owner and remaining-word counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr      <= '0;
      r_grant   <= '0;
      r_cfg_rem <= 10'd0;
      r_pkt_rem <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_ARB && w_found) begin
        r_grant   <= w_sel;
        r_rr      <= w_rr_nxt;
        r_cfg_rem <= w_sel_cfg;
        r_pkt_rem <= w_sel_pkt;
      end else if (r_state == S_CFG && w_hs) begin
        r_cfg_rem <= r_cfg_rem - 10'd1;
      end else if (r_state == S_DATA && w_hs) begin
        r_pkt_rem <= r_pkt_rem - CNT_W'(1);
      end
    end
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_router_frame_arbiter.sv
// Self-checking bench for router_frame_arbiter. Stimulus is driven once per
// clock. Frames are predicted from the scheduling rules: round-robin selection
// over the pending descriptors, a header of pkt_cnt*1024+cfg_len, and then
// the next cfg_len+pkt_cnt words of the owner.
module tb_router_frame_arbiter;
  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int MAXC = 8;
  localparam int CW   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    s_req_valid, s_req_ready, req_err;
  logic [N*10-1:0] s_req_cfg_len;
  logic [N*CW-1:0] s_req_pkt_cnt;
  logic [N*DW-1:0] s_axis_src_data;
  logic [N-1:0]    s_axis_src_valid, s_axis_src_ready;
  logic [DW-1:0]   m_data;
  logic            m_valid, m_ready, busy;
  logic [1:0]      grant_id;

  router_frame_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .MAX_CFG_LEN(MAXC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_cfg_len(s_req_cfg_len), .s_req_pkt_cnt(s_req_pkt_cnt),
    .s_axis_src_data(s_axis_src_data), .s_axis_src_valid(s_axis_src_valid),
    .s_axis_src_ready(s_axis_src_ready),
    .m_axis_router_input(m_data), .m_axis_router_input_valid(m_valid),
    .m_axis_router_input_ready(m_ready),
    .grant_id(grant_id), .busy(busy), .req_err(req_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // bench-side sources
  int            rq_cfg[N][$];
  int            rq_pkt[N][$];
  logic [DW-1:0] src_q[N][$];
  bit            src_hold[N];
  bit            stall;
  // reference model state
  int            md_cfg[N][$];
  int            md_pkt[N][$];
  logic [DW-1:0] md_words[N][$];
  int            m_rr;
  // observations
  logic [DW-1:0] obs_q[$];
  int            obs_gnt[$];
  int            rdy_order[$];
  int            err_order[$];
  int            srdy_cnt[N];
  int            stab_viol, own_viol, cyc, first_mv;
  bit            prev_hold_m;
  logic [DW-1:0] prev_data;
  // expectations
  logic [DW-1:0] exp_beats[$];
  int            exp_gnt[$];
  int            exp_order[$];
  int            exp_err[$];

  task automatic clear_obs();
    obs_q.delete(); obs_gnt.delete(); rdy_order.delete(); err_order.delete();
    for (int s = 0; s < N; s++) srdy_cnt[s] = 0;
    stab_viol = 0; own_viol = 0; first_mv = -1;
  endtask

  task automatic post(input int s, input int c, input int p);
    rq_cfg[s].push_back(c); rq_pkt[s].push_back(p);
    md_cfg[s].push_back(c); md_pkt[s].push_back(p);
    if (c <= MAXC) begin
      for (int k = 0; k < c + p; k++) begin
        logic [DW-1:0] w;
        w = {$urandom, $urandom};
        src_q[s].push_back(w);
        md_words[s].push_back(w);
      end
    end
  endtask

  // Reference model: serve every pending descriptor in round-robin order.
  task automatic model_run();
    int g, c, p;
    exp_beats.delete(); exp_gnt.delete(); exp_order.delete(); exp_err.delete();
    while (1) begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        if (g < 0 && md_cfg[(m_rr + i) % N].size() > 0) g = (m_rr + i) % N;
      end
      if (g < 0) break;
      c = md_cfg[g].pop_front();
      p = md_pkt[g].pop_front();
      exp_order.push_back(g);
      m_rr = (g + 1) % N;
      if (c > MAXC) begin
        exp_err.push_back(g);
      end else begin
        exp_beats.push_back(DW'(p) * 64'd1024 + DW'(c));
        exp_gnt.push_back(g);
        for (int k = 0; k < c + p; k++) begin
          exp_beats.push_back(md_words[g].pop_front());
          exp_gnt.push_back(g);
        end
      end
    end
  endtask

  // One clock: drive at negedge, sample the settled values 1ns later.
  task automatic step();
    @(negedge clk);
    for (int s = 0; s < N; s++) begin
      s_req_valid[s] = (rq_cfg[s].size() > 0);
      if (rq_cfg[s].size() > 0) begin
        s_req_cfg_len[s*10 +: 10] = 10'(rq_cfg[s][0]);
        s_req_pkt_cnt[s*CW +: CW] = 16'(rq_pkt[s][0]);
      end
      if (src_q[s].size() > 0 && (src_hold[s] || !stall || $urandom_range(0, 2) != 0)) begin
        s_axis_src_valid[s] = 1'b1;
        s_axis_src_data[s*DW +: DW] = src_q[s][0];
      end else begin
        s_axis_src_valid[s] = 1'b0;
        s_axis_src_data[s*DW +: DW] = '0;
      end
    end
    m_ready = !stall || ($urandom_range(0, 2) != 0);
    #1;
    cyc++;
    if (prev_hold_m && (!m_valid || m_data !== prev_data)) stab_viol++;
    prev_hold_m = m_valid && !m_ready;
    prev_data   = m_data;
    if (s_axis_src_ready != '0 && s_axis_src_ready != (4'b0001 << grant_id)) own_viol++;
    if (m_valid && first_mv < 0) first_mv = cyc;
    for (int s = 0; s < N; s++) begin
      if (s_axis_src_ready[s]) srdy_cnt[s]++;
      src_hold[s] = s_axis_src_valid[s] && !s_axis_src_ready[s];
      if (s_axis_src_valid[s] && s_axis_src_ready[s]) void'(src_q[s].pop_front());
      if (s_req_ready[s]) begin
        rdy_order.push_back(s);
        void'(rq_cfg[s].pop_front());
        void'(rq_pkt[s].pop_front());
      end
      if (req_err[s]) err_order.push_back(s);
    end
    if (m_valid && m_ready) begin
      obs_q.push_back(m_data);
      obs_gnt.push_back(int'(grant_id));
    end
  endtask

  task automatic run_idle(input int limit, output bit to);
    int n;
    bit work;
    n = 0;
    work = 1'b1;
    while (work && n < limit) begin
      step();
      n++;
      work = busy;
      for (int s = 0; s < N; s++) if (rq_cfg[s].size() > 0 || src_q[s].size() > 0) work = 1'b1;
    end
    to = work;
    step();
  endtask

  task automatic test_reset();
    s_req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({s_req_ready, s_axis_src_ready, req_err, m_valid, busy, grant_id} !== '0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b srdy=%b err=%b v=%b busy=%b gnt=%0d data=%h want all 0",
               s_req_ready, s_axis_src_ready, req_err, m_valid, busy, grant_id, m_data);
    end
    s_req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    string nm;
    bit to;
    nm = "round_robin";
    clear_obs();
    for (int s = 0; s < N; s++) post(s, 1, 1);
    post(0, 1, 1);
    model_run();
    run_idle(400, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL %s timeout: got 1 want 0", nm); end
    n_checks++;
    if (rdy_order.size() !== exp_order.size()) begin n_fail++; $display("FAIL %s grants: got %0d want %0d", nm, rdy_order.size(), exp_order.size()); end
    for (int i = 0; i < rdy_order.size() && i < exp_order.size(); i++) begin
      n_checks++;
      if (rdy_order[i] !== exp_order[i]) begin n_fail++; $display("FAIL %s grant[%0d]: got %0d want %0d", nm, i, rdy_order[i], exp_order[i]); end
    end
    n_checks++;
    if (obs_q.size() !== exp_beats.size()) begin n_fail++; $display("FAIL %s beats: got %0d want %0d", nm, obs_q.size(), exp_beats.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_beats.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_beats[i] || obs_gnt[i] !== exp_gnt[i]) begin
        n_fail++; $display("FAIL %s beat[%0d]: got %h/g%0d want %h/g%0d", nm, i, obs_q[i], obs_gnt[i], exp_beats[i], exp_gnt[i]);
      end
    end
  endtask

  task automatic test_basic();
    string nm;
    bit to;
    int c0;
    nm = "basic";
    clear_obs();
    post(0, 2, 3);
    model_run();
    c0 = cyc + 1;
    run_idle(200, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL %s timeout: got 1 want 0", nm); end
    n_checks++;
    if (first_mv !== c0 + 2) begin n_fail++; $display("FAIL %s latency: got cycle %0d want %0d", nm, first_mv, c0 + 2); end
    n_checks++;
    if (obs_q.size() !== 6 || obs_q[0] !== 64'h0000_0000_0000_0C02) begin
      n_fail++; $display("FAIL %s header: got n=%0d hdr=%h want n=6 hdr=0000000000000c02", nm, obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 64'h0);
    end
    for (int i = 0; i < obs_q.size() && i < exp_beats.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_beats[i]) begin n_fail++; $display("FAIL %s beat[%0d]: got %h want %h", nm, i, obs_q[i], exp_beats[i]); end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after: got %b want 0", nm, busy); end
  endtask

  task automatic test_zero_len();
    string nm;
    bit to;
    nm = "zero_len";
    clear_obs();
    post(2, 0, 0);
    model_run();
    run_idle(100, to);
    n_checks++;
    if (to !== 1'b0 || obs_q.size() !== 1) begin n_fail++; $display("FAIL %s hdr_only: got timeout=%b n=%0d want 0/1", nm, to, obs_q.size()); end
    n_checks++;
    if (obs_q.size() > 0 && obs_q[0] !== 64'h0) begin n_fail++; $display("FAIL %s hdr_value: got %h want 0", nm, obs_q[0]); end
    n_checks++;
    if (srdy_cnt[2] !== 0) begin n_fail++; $display("FAIL %s src_ready2: got %0d cycles want 0", nm, srdy_cnt[2]); end
    clear_obs();
    post(2, 0, 4);
    model_run();
    run_idle(100, to);
    n_checks++;
    if (to !== 1'b0 || obs_q.size() !== 5) begin n_fail++; $display("FAIL %s data_only: got timeout=%b n=%0d want 0/5", nm, to, obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_beats.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_beats[i]) begin n_fail++; $display("FAIL %s beat[%0d]: got %h want %h", nm, i, obs_q[i], exp_beats[i]); end
    end
  endtask

  task automatic test_cfg_err();
    string nm;
    bit to;
    nm = "cfg_err";
    clear_obs();
    post(1, 9, 3);
    post(2, 1, 2);
    model_run();
    run_idle(200, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL %s timeout: got 1 want 0", nm); end
    n_checks++;
    if (err_order.size() !== exp_err.size() || (err_order.size() > 0 && err_order[0] !== 1)) begin
      n_fail++; $display("FAIL %s req_err: got %0d pulses want %0d on src1", nm, err_order.size(), exp_err.size());
    end
    n_checks++;
    if (rdy_order.size() !== exp_order.size()) begin n_fail++; $display("FAIL %s grants: got %0d want %0d", nm, rdy_order.size(), exp_order.size()); end
    for (int i = 0; i < rdy_order.size() && i < exp_order.size(); i++) begin
      n_checks++;
      if (rdy_order[i] !== exp_order[i]) begin n_fail++; $display("FAIL %s grant[%0d]: got %0d want %0d", nm, i, rdy_order[i], exp_order[i]); end
    end
    n_checks++;
    if (obs_q.size() !== exp_beats.size()) begin n_fail++; $display("FAIL %s beats: got %0d want %0d", nm, obs_q.size(), exp_beats.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_beats.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_beats[i] || obs_gnt[i] !== exp_gnt[i]) begin
        n_fail++; $display("FAIL %s beat[%0d]: got %h/g%0d want %h/g%0d", nm, i, obs_q[i], obs_gnt[i], exp_beats[i], exp_gnt[i]);
      end
    end
  endtask

  task automatic test_stall_random();
    string nm;
    bit to;
    nm = "stall_random";
    clear_obs();
    stall = 1'b1;
    post($urandom_range(0, N - 1), 8, 100);
    post($urandom_range(0, N - 1), $urandom_range(0, MAXC), $urandom_range(1, 20));
    model_run();
    run_idle(3000, to);
    stall = 1'b0;
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL %s timeout: got 1 want 0", nm); end
    n_checks++;
    if (obs_q.size() !== exp_beats.size()) begin n_fail++; $display("FAIL %s beats: got %0d want %0d", nm, obs_q.size(), exp_beats.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_beats.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_beats[i] || obs_gnt[i] !== exp_gnt[i]) begin
        n_fail++; $display("FAIL %s beat[%0d]: got %h/g%0d want %h/g%0d", nm, i, obs_q[i], obs_gnt[i], exp_beats[i], exp_gnt[i]);
      end
    end
    n_checks++;
    if (stab_viol !== 0) begin n_fail++; $display("FAIL %s stable_under_stall: got %0d violations want 0", nm, stab_viol); end
    n_checks++;
    if (own_viol !== 0) begin n_fail++; $display("FAIL %s src_ready_owner: got %0d violations want 0", nm, own_viol); end
  endtask

  task automatic test_reset_mid();
    string nm;
    bit to;
    int n;
    nm = "reset_mid";
    clear_obs();
    post(3, 1, 20);
    model_run();
    n = 0;
    while (obs_q.size() < 5 && n < 200) begin step(); n++; end
    n_checks++;
    if (n >= 200) begin n_fail++; $display("FAIL %s reach_data: got %0d beats want 5", nm, obs_q.size()); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({s_req_ready, s_axis_src_ready, req_err, m_valid, busy, grant_id} !== '0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL %s outputs: got srdy=%b v=%b busy=%b gnt=%0d data=%h want all 0", nm, s_axis_src_ready, m_valid, busy, grant_id, m_data);
    end
    for (int s = 0; s < N; s++) begin
      rq_cfg[s].delete(); rq_pkt[s].delete(); src_q[s].delete();
      md_cfg[s].delete(); md_pkt[s].delete(); md_words[s].delete();
      src_hold[s] = 1'b0;
    end
    m_rr = 0;
    prev_hold_m = 1'b0;
    s_req_valid = '0;
    s_axis_src_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    clear_obs();
    post(1, 2, 2);
    model_run();
    run_idle(200, to);
    n_checks++;
    if (to !== 1'b0 || obs_q.size() !== exp_beats.size()) begin
      n_fail++; $display("FAIL %s after_reset: got timeout=%b n=%0d want 0/%0d", nm, to, obs_q.size(), exp_beats.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_beats.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_beats[i] || obs_gnt[i] !== 1) begin
        n_fail++; $display("FAIL %s beat[%0d]: got %h/g%0d want %h/g1", nm, i, obs_q[i], obs_gnt[i], exp_beats[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    s_req_valid = '0; s_req_cfg_len = '0; s_req_pkt_cnt = '0;
    s_axis_src_data = '0; s_axis_src_valid = '0; m_ready = 1'b0;
    stall = 1'b0; m_rr = 0; cyc = 0; prev_hold_m = 1'b0; prev_data = '0;
    for (int s = 0; s < N; s++) src_hold[s] = 1'b0;
    clear_obs();
    test_reset();
    test_round_robin();
    test_basic();
    test_zero_len();
    test_cfg_err();
    test_stall_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
